ec_point_add: RTL and testbench

Affine elliptic-curve point adder/doubler over secp256k1: y² = x³ + 7 mod p, where p = FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFE FFFFFC2F. It computes R = P1 + P2 with full handling of the point at infinity, and uses the doubling formula when P1 = P2. It is the single arithmetic engine driven by the scalar-multiplication sequencer, which uses it for both R += P and P = 2P. It is a multi-cycle start/done block built from a sequential modular multiplier and a modular inverter.

---
 rtl/ec_point_add.sv | 196 +++++++++++++++++++
 tb/tb_ec_point_add.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ec_point_add.sv
// Affine point add/double on secp256k1, built on a bit-serial modular
// multiplier and a binary extended-Euclid inverter sharing one FSM.
module ec_point_add (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] x1,
    input  logic [255:0] y1,
    input  logic         inf1,
    input  logic [255:0] x2,
    input  logic [255:0] y2,
    input  logic         inf2,
    output logic         done,
    output logic [255:0] x3,
    output logic [255:0] y3,
    output logic         inf3
);

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [2:0] {IDLE, CLASSIFY, INV, MUL, FINISH} state_t;

    function automatic logic [255:0] add_p(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    // a - b + P wraps mod 2^256 to the correct residue when a < b
    function automatic logic [255:0] sub_p(input logic [255:0] a, input logic [255:0] b);
        return (a >= b) ? (a - b) : (a - b + P);
    endfunction

    function automatic logic [255:0] half_p(input logic [255:0] a);
        logic [256:0] s;
        s = a[0] ? ({1'b0, a} + {1'b0, P}) : {1'b0, a};
        return s[256:1];
    endfunction

    state_t state, state_next;

    logic [255:0] px1, py1, px2, py2;
    logic         pinf1, pinf2;
    logic [255:0] u, v, s1, s2, inv;
    logic [255:0] num, lam, rx, acc;
    logic [7:0]   cnt;
    logic [1:0]   op;

    logic         trivial, dbl;
    logic [255:0] tr_x, tr_y;
    logic         tr_inf;
    logic [255:0] ma, mb, acc_dbl, acc_next;
    logic         inv_done, mul_last;
    logic [255:0] fin_x, fin_y;
    logic         fin_inf;

    always_comb begin
        trivial = 1'b1;
        dbl     = 1'b0;
        tr_x    = '0;
        tr_y    = '0;
        tr_inf  = 1'b1;
        if (pinf1) begin
            tr_inf = pinf2;
            tr_x   = pinf2 ? '0 : px2;
            tr_y   = pinf2 ? '0 : py2;
        end else if (pinf2) begin
            tr_x   = px1;
            tr_y   = py1;
            tr_inf = 1'b0;
        end else if (px1 == px2 && (py1 != py2 || py1 == '0)) begin
            tr_inf = 1'b1;
        end else begin
            trivial = 1'b0;
            dbl     = (px1 == px2);
        end
    end

    // op 0: x1^2, op 1: num*inv, op 2: lam^2, op 3: lam*(x1-x3)
    always_comb begin
        ma = lam;
        mb = lam;
        case (op)
            2'd0: begin ma = px1; mb = px1; end
            2'd1: begin ma = num; mb = inv; end
            2'd3: mb = sub_p(px1, rx);
            default: ;
        endcase
        acc_dbl  = add_p(acc, acc);
        acc_next = mb[cnt] ? add_p(acc_dbl, ma) : acc_dbl;
    end

    assign inv_done = (u == 256'd1) || (v == 256'd1);
    assign mul_last = (state == MUL) && (cnt == 8'd0);

    always_comb begin
        fin_x   = rx;
        fin_y   = sub_p(acc_next, py1);
        fin_inf = 1'b0;
        if (state == CLASSIFY) begin
            fin_x   = tr_x;
            fin_y   = tr_y;
            fin_inf = tr_inf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE:     if (start) state_next = CLASSIFY;
            CLASSIFY: state_next = trivial ? FINISH : INV;
            INV:      if (inv_done) state_next = MUL;
            MUL:      if (mul_last && op == 2'd3) state_next = FINISH;
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px1 <= '0; py1 <= '0; pinf1 <= 1'b0;
            px2 <= '0; py2 <= '0; pinf2 <= 1'b0;
            u   <= '0; v   <= '0; s1 <= '0; s2 <= '0; inv <= '0;
            num <= '0; lam <= '0; rx <= '0; acc <= '0;
            cnt <= '0; op  <= '0;
            x3  <= '0; y3  <= '0; inf3 <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    px1 <= x1; py1 <= y1; pinf1 <= inf1;
                    px2 <= x2; py2 <= y2; pinf2 <= inf2;
                end
                CLASSIFY: begin
                    u   <= dbl ? add_p(py1, py1) : sub_p(px2, px1);
                    v   <= P;
                    s1  <= 256'd1;
                    s2  <= '0;
                    num <= sub_p(py2, py1);
                    op  <= dbl ? 2'd0 : 2'd1;
                    acc <= '0;
                    cnt <= 8'd255;
                end
                INV: begin
                    // invariants: s1*d = u, s2*d = v (mod p)
                    if (inv_done) begin
                        inv <= (u == 256'd1) ? s1 : s2;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        s1 <= half_p(s1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        s2 <= half_p(s2);
                    end else if (u >= v) begin
                        u  <= (u - v) >> 1;
                        s1 <= half_p(sub_p(s1, s2));
                    end else begin
                        v  <= (v - u) >> 1;
                        s2 <= half_p(sub_p(s2, s1));
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        acc <= '0;
                        op  <= op + 2'd1;
                        case (op)
                            2'd0: num <= add_p(add_p(acc_next, acc_next), acc_next);
                            2'd1: lam <= acc_next;
                            2'd2: rx  <= sub_p(sub_p(acc_next, px1), px2);
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
            if (state_next == FINISH) begin
                x3   <= fin_x;
                y3   <= fin_y;
                inf3 <= fin_inf;
            end
        end
    end

endmodule

// File: tb/tb_ec_point_add.sv
// Scoreboard bench for ec_point_add: known multiples of the secp256k1
// generator, infinity handling, latency, reset abort and busy start.
module tb_ec_point_add;

    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] NGY = 256'hB7C52588D95C3B9AA25B0403F1EEF75702E84BB7597AABE663B82F6F04EF2777;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [255:0] G3X = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam logic [255:0] G3Y = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
    localparam int LIMIT = 2100;

    typedef struct {
        logic [255:0] x;
        logic [255:0] y;
        logic         inf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, done;
    logic [255:0] x1, y1, x2, y2, x3, y3;
    logic         inf1, inf2, inf3;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    ec_point_add dut (
        .clk(clk), .rst(rst), .start(start),
        .x1(x1), .y1(y1), .inf1(inf1),
        .x2(x2), .y2(y2), .inf2(inf2),
        .done(done), .x3(x3), .y3(y3), .inf3(inf3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic issue(input logic [255:0] ax, input logic [255:0] ay, input logic ai,
                         input logic [255:0] bx, input logic [255:0] by, input logic bi,
                         input logic [255:0] ex, input logic [255:0] ey, input logic ei);
        exp_t e;
        @(negedge clk);
        x1 = ax; y1 = ay; inf1 = ai;
        x2 = bx; y2 = by; inf2 = bi;
        start = 1'b1;
        e.x = ex; e.y = ey; e.inf = ei;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        x1 = ~ax; y1 = ~ay; inf1 = ~ai;
        x2 = ~bx; y2 = ~by; inf2 = ~bi;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; inf1 = 1'b0; inf2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || x3 !== '0 || y3 !== '0 || inf3 !== 1'b1) begin
            errors++;
            $display("FAIL reset: done=%b x3=%h y3=%h inf3=%b, want 0/0/0/1", done, x3, y3, inf3);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_double;
        int cyc, base;
        exp_t e;
        base = done_cnt;
        issue(GX, GY, 1'b0, GX, GY, 1'b0, G2X, G2Y, 1'b0);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc + 1 > 2048) begin
            errors++;
            $display("FAIL double_latency: latency=%0d, want done within 2048", cyc + 1);
        end
        checks++;
        if (x3 !== e.x || y3 !== e.y || inf3 !== e.inf) begin
            errors++;
            $display("FAIL double: got %h %h %b want %h %h %b", x3, y3, inf3, e.x, e.y, e.inf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle after completion, want 0", done);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != base + 1 || x3 !== e.x || y3 !== e.y) begin
            errors++;
            $display("FAIL double_hold: pulses=%0d want 1, x3=%h", done_cnt - base, x3);
        end
    endtask

    task automatic test_add;
        logic [255:0] ax[2] = '{G2X, GX};
        logic [255:0] ay[2] = '{G2Y, GY};
        logic [255:0] bx[2] = '{GX, G2X};
        logic [255:0] by[2] = '{GY, G2Y};
        for (int i = 0; i < 2; i++) begin
            int cyc;
            exp_t e;
            issue(ax[i], ay[i], 1'b0, bx[i], by[i], 1'b0, G3X, G3Y, 1'b0);
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (done !== 1'b1 || x3 !== e.x || y3 !== e.y || inf3 !== e.inf) begin
                errors++;
                $display("FAIL add%0d: done=%b got %h %h %b want %h %h %b",
                         i, done, x3, y3, inf3, e.x, e.y, e.inf);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_trivial;
        logic [255:0] ax[4] = '{GX, GX, 256'h5, GX};
        logic [255:0] ay[4] = '{GY, GY, 256'h6, GY};
        logic         ai[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [255:0] bx[4] = '{GX, G2X, 256'h7, GX};
        logic [255:0] by[4] = '{GY, G2Y, 256'h8, NGY};
        logic         bi[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [255:0] ex[4] = '{GX, GX, 256'h0, 256'h0};
        logic [255:0] ey[4] = '{GY, GY, 256'h0, 256'h0};
        logic         ei[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            int cyc;
            exp_t e;
            issue(ax[i], ay[i], ai[i], bx[i], by[i], bi[i], ex[i], ey[i], ei[i]);
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (done !== 1'b1 || cyc + 1 != 2) begin
                errors++;
                $display("FAIL trivial%0d_latency: latency=%0d, want 2", i, cyc + 1);
            end
            checks++;
            if (x3 !== e.x || y3 !== e.y || inf3 !== e.inf) begin
                errors++;
                $display("FAIL trivial%0d: got %h %h %b want %h %h %b",
                         i, x3, y3, inf3, e.x, e.y, e.inf);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_abort;
        int cyc, base;
        exp_t e;
        base = done_cnt;
        issue(GX, GY, 1'b0, GX, GY, 1'b0, G2X, G2Y, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (1700) @(negedge clk);
        checks++;
        if (done_cnt != base || x3 !== '0 || y3 !== '0 || inf3 !== 1'b1) begin
            errors++;
            $display("FAIL abort: pulses=%0d want 0, x3=%h y3=%h inf3=%b want reset values",
                     done_cnt - base, x3, y3, inf3);
        end
        issue(G2X, G2Y, 1'b0, GX, GY, 1'b0, G3X, G3Y, 1'b0);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || x3 !== e.x || y3 !== e.y || inf3 !== e.inf) begin
            errors++;
            $display("FAIL after_abort: done=%b got %h %h %b want %h %h %b",
                     done, x3, y3, inf3, e.x, e.y, e.inf);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_start;
        int cyc, base;
        exp_t e;
        base = done_cnt;
        issue(GX, GY, 1'b0, GX, GY, 1'b0, G2X, G2Y, 1'b0);
        repeat (10) @(negedge clk);
        x1 = G3X; y1 = G3Y; inf1 = 1'b1; x2 = G3X; y2 = G3Y; inf2 = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || x3 !== e.x || y3 !== e.y || inf3 !== e.inf) begin
            errors++;
            $display("FAIL busy: done=%b got %h %h %b want %h %h %b",
                     done, x3, y3, inf3, e.x, e.y, e.inf);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != base + 1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_pulses: pulses=%0d done=%b, want 1 pulse", done_cnt - base, done);
        end
    endtask

    initial begin
        test_reset();
        test_double();
        test_add();
        test_trivial();
        test_reset_abort();
        test_busy_start();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
